// File: rtl/fu_issue_scheduler.sv
// Issue-select controller for the reservation station: tracks live entries, their age order
// and FU binding, and grants the oldest ready entry to each free functional unit.
module fu_issue_scheduler #(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter int unsigned NUM_FU      = 3,
    parameter int unsigned IDX_W       = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_flush,
    input  logic [1:0]                i_ins_valid,
    input  logic [2*IDX_W-1:0]        i_ins_idx,
    input  logic [3:0]                i_ins_fu,
    input  logic [NUM_ENTRIES-1:0]    i_ready,
    input  logic [NUM_FU-1:0]         i_fu_done,
    output logic [NUM_FU-1:0]         o_grant_valid,
    output logic [NUM_FU*IDX_W-1:0]   o_grant_idx,
    output logic [NUM_FU-1:0]         o_fu_busy,
    output logic [IDX_W:0]            o_occupancy,
    output logic                      o_ins_err
);

    localparam logic [1:0] FuIllegal = 2'd3;

    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [1:0]             fu_q [NUM_ENTRIES];
    logic [1:0]             fu_d [NUM_ENTRIES];
    // older_q[i][j] set means entry i is older than entry j
    logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] older_d [NUM_ENTRIES];
    logic [NUM_FU-1:0]      busy_q, busy_d;
    logic [NUM_FU-1:0]      gvalid_q, gvalid_d;
    logic [IDX_W-1:0]       gidx_q [NUM_FU];
    logic [IDX_W-1:0]       gidx_d [NUM_FU];
    logic [IDX_W:0]         occ_q, occ_d;
    logic                   err_q, err_d;

    logic [NUM_FU-1:0]      fu_free;
    logic [NUM_ENTRIES-1:0] older_col [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] elig [NUM_FU];
    logic [NUM_ENTRIES-1:0] sel  [NUM_FU];
    logic [NUM_ENTRIES-1:0] gnt_clr;
    logic [NUM_ENTRIES-1:0] live;

    logic [IDX_W-1:0] idx0, idx1;
    logic [1:0]       ins_fu0, ins_fu1;
    logic             ok0, ok1, bad1;

    assign idx0    = i_ins_idx[IDX_W-1:0];
    assign idx1    = i_ins_idx[2*IDX_W-1:IDX_W];
    assign ins_fu0 = i_ins_fu[1:0];
    assign ins_fu1 = i_ins_fu[3:2];

    // Column view of the age matrix with the diagonal masked off
    always_comb begin
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            for (int k = 0; k < NUM_ENTRIES; k++) begin
                older_col[e][k] = (k != e) && older_q[k][e];
            end
        end
    end

    always_comb begin
        fu_free = ~busy_q | i_fu_done;
        for (int f = 0; f < NUM_FU; f++) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                elig[f][e] = valid_q[e] && i_ready[e] && (fu_q[e] == 2'(f)) && fu_free[f];
            end
        end
    end

    always_comb begin
        for (int f = 0; f < NUM_FU; f++) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                sel[f][e] = elig[f][e] && !(|(older_col[e] & elig[f]));
            end
        end
    end

    always_comb begin
        gnt_clr  = '0;
        gvalid_d = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            gvalid_d[f] = |sel[f];
            gidx_d[f]   = gidx_q[f];
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                if (sel[f][e]) begin
                    gidx_d[f] = IDX_W'(e);
                end
            end
            gnt_clr = gnt_clr | sel[f];
        end
    end

    // An entry being granted this cycle may be re-inserted; it frees up at this edge
    assign live = valid_q & ~gnt_clr;
    assign ok0  = i_ins_valid[0] && (ins_fu0 != FuIllegal) && !live[idx0];
    assign bad1 = (ins_fu1 == FuIllegal) || live[idx1] || (i_ins_valid[0] && (idx1 == idx0));
    assign ok1  = i_ins_valid[1] && !bad1;
    assign err_d = (i_ins_valid[0] && !ok0) || (i_ins_valid[1] && !ok1);

    always_comb begin
        valid_d = live;
        fu_d    = fu_q;
        older_d = older_q;
        if (ok0) begin
            valid_d[idx0] = 1'b1;
            fu_d[idx0]    = ins_fu0;
            older_d[idx0] = '0;
            for (int k = 0; k < NUM_ENTRIES; k++) begin
                older_d[k][idx0] = live[k] && (k != int'(idx0));
            end
        end
        if (ok1) begin
            valid_d[idx1] = 1'b1;
            fu_d[idx1]    = ins_fu1;
            older_d[idx1] = '0;
            for (int k = 0; k < NUM_ENTRIES; k++) begin
                older_d[k][idx1] = (live[k] || (ok0 && (k == int'(idx0)))) &&
                                   (k != int'(idx1));
            end
        end
    end

    always_comb begin
        occ_d = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            occ_d = occ_d + {{IDX_W{1'b0}}, valid_d[e]};
        end
    end

    // A done and a new grant at the same edge keep the FU busy with no bubble
    assign busy_d = (busy_q & ~i_fu_done) | gvalid_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            valid_q  <= '0;
            busy_q   <= '0;
            gvalid_q <= '0;
            occ_q    <= '0;
            err_q    <= 1'b0;
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                fu_q[e]    <= '0;
                older_q[e] <= '0;
            end
            for (int f = 0; f < NUM_FU; f++) begin
                gidx_q[f] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            gvalid_q <= gvalid_d;
            occ_q    <= occ_d;
            err_q    <= err_d;
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                fu_q[e]    <= fu_d[e];
                older_q[e] <= older_d[e];
            end
            for (int f = 0; f < NUM_FU; f++) begin
                gidx_q[f] <= gidx_d[f];
            end
        end
    end

    always_comb begin
        o_grant_idx = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            o_grant_idx[f*IDX_W +: IDX_W] = gidx_q[f];
        end
    end

    assign o_grant_valid = gvalid_q;
    assign o_fu_busy     = busy_q;
    assign o_occupancy   = occ_q;
    assign o_ins_err     = err_q;

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Directed bench for fu_issue_scheduler: expected grants go into a scoreboard queue that a
// negedge monitor drains; status outputs are checked inline after each edge.
module tb_fu_issue_scheduler;

    localparam int NE = 16;
    localparam int NF = 3;
    localparam int IW = 4;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic            i_flush = 1'b0;
    logic [1:0]      i_ins_valid = '0;
    logic [2*IW-1:0] i_ins_idx = '0;
    logic [3:0]      i_ins_fu = '0;
    logic [NE-1:0]   i_ready = '0;
    logic [NF-1:0]   i_fu_done = '0;
    logic [NF-1:0]   o_grant_valid;
    logic [NF*IW-1:0] o_grant_idx;
    logic [NF-1:0]   o_fu_busy;
    logic [IW:0]     o_occupancy;
    logic            o_ins_err;

    fu_issue_scheduler #(
        .NUM_ENTRIES(NE),
        .NUM_FU     (NF),
        .IDX_W      (IW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (i_flush),
        .i_ins_valid  (i_ins_valid),
        .i_ins_idx    (i_ins_idx),
        .i_ins_fu     (i_ins_fu),
        .i_ready      (i_ready),
        .i_fu_done    (i_fu_done),
        .o_grant_valid(o_grant_valid),
        .o_grant_idx  (o_grant_idx),
        .o_fu_busy    (o_fu_busy),
        .o_occupancy  (o_occupancy),
        .o_ins_err    (o_ins_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [1:0]  fu;
        logic [3:0]  idx;
        logic [31:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Grant shows up on the edge after the current cycle
    task automatic expect_grant(input int f, input int idx);
        exp_t e;
        e.fu  = 2'(f);
        e.idx = 4'(idx);
        e.cyc = 32'(cyc + 1);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic ins(input logic [1:0] v, input int i0, input int f0, input int i1,
                       input int f1);
        i_ins_valid = v;
        i_ins_idx   = {4'(i1), 4'(i0)};
        i_ins_fu    = {2'(f1), 2'(f0)};
        tick();
        i_ins_valid = '0;
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        logic hit;
        for (int f = 0; f < NF; f++) begin
            hit = (exp_q.size() > 0) && (int'(exp_q[0].fu) == f) && (int'(exp_q[0].cyc) == cyc);
            if (o_grant_valid[f]) begin
                if (hit) begin
                    e = exp_q.pop_front();
                    check($sformatf("grant_idx_fu%0d", f), 32'(o_grant_idx[f*IW +: IW]),
                          32'(e.idx));
                end else begin
                    check($sformatf("spurious_grant_fu%0d", f), 32'(o_grant_valid[f]), 0);
                end
            end else if (hit) begin
                e = exp_q.pop_front();
                check($sformatf("missing_grant_fu%0d_idx%0d", f, e.idx),
                      32'(o_grant_valid[f]), 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();

        // Reset wins over concurrent inserts
        i_rst_n     = 1'b0;
        i_ins_valid = 2'b11;
        i_ins_idx   = {4'd5, 4'd3};
        i_ins_fu    = {2'd1, 2'd0};
        tick();
        i_ins_valid = '0;
        i_rst_n     = 1'b1;
        check("rst_occ", 32'(o_occupancy), 0);
        check("rst_gv", 32'(o_grant_valid), 0);
        check("rst_busy", 32'(o_fu_busy), 0);
        check("rst_err", 32'(o_ins_err), 0);
        tick();
        check("rst_occ_after", 32'(o_occupancy), 0);

        // Age order on FU0
        ins(2'b01, 7, 0, 0, 0);
        ins(2'b01, 2, 0, 0, 0);
        check("age_occ", 32'(o_occupancy), 2);
        tick();
        i_ready = (NE'(1) << 7) | (NE'(1) << 2);
        expect_grant(0, 7);
        tick();
        check("age_busy1", 32'(o_fu_busy), 1);
        check("age_occ1", 32'(o_occupancy), 1);
        i_fu_done = 3'b001;
        expect_grant(0, 2);
        tick();
        i_fu_done = '0;
        check("age_busy_b2b", 32'(o_fu_busy), 1);
        check("age_occ0", 32'(o_occupancy), 0);
        tick();
        check("age_busy_hold", 32'(o_fu_busy), 1);
        i_fu_done = 3'b001;
        tick();
        i_fu_done = '0;
        i_ready   = '0;
        check("age_busy_clr", 32'(o_fu_busy), 0);

        // Dual insert: slot 0 is older
        ins(2'b11, 9, 1, 1, 1);
        check("dual_occ", 32'(o_occupancy), 2);
        i_ready = (NE'(1) << 9) | (NE'(1) << 1);
        expect_grant(1, 9);
        tick();
        i_fu_done = 3'b010;
        expect_grant(1, 1);
        tick();
        tick();
        i_fu_done = '0;
        i_ready   = '0;
        check("dual_busy", 32'(o_fu_busy), 0);
        check("dual_occ0", 32'(o_occupancy), 0);

        // Parallel FUs, second FU2 entry waits for done
        ins(2'b11, 10, 0, 11, 1);
        ins(2'b11, 12, 2, 13, 2);
        i_ready = (NE'(1) << 10) | (NE'(1) << 11) | (NE'(1) << 12) | (NE'(1) << 13);
        expect_grant(0, 10);
        expect_grant(1, 11);
        expect_grant(2, 12);
        tick();
        check("par_busy", 32'(o_fu_busy), 7);
        check("par_gv", 32'(o_grant_valid), 7);
        tick();
        tick();
        check("par_hold_occ", 32'(o_occupancy), 1);
        i_fu_done = 3'b100;
        expect_grant(2, 13);
        tick();
        i_fu_done = '0;
        check("par_busy2", 32'(o_fu_busy), 7);
        i_fu_done = 3'b111;
        tick();
        i_fu_done = '0;
        i_ready   = '0;
        check("par_busy_clr", 32'(o_fu_busy), 0);
        check("par_occ0", 32'(o_occupancy), 0);

        // Illegal inserts
        ins(2'b01, 4, 0, 0, 0);
        check("ill_first_err", 32'(o_ins_err), 0);
        check("ill_first_occ", 32'(o_occupancy), 1);
        ins(2'b01, 4, 1, 0, 0);
        check("ill_dup_err", 32'(o_ins_err), 1);
        check("ill_dup_occ", 32'(o_occupancy), 1);
        tick();
        check("ill_err_pulse", 32'(o_ins_err), 0);
        ins(2'b01, 6, 3, 0, 0);
        check("ill_fu3_err", 32'(o_ins_err), 1);
        check("ill_fu3_occ", 32'(o_occupancy), 1);
        ins(2'b11, 8, 0, 8, 1);
        check("ill_sameidx_err", 32'(o_ins_err), 1);
        check("ill_sameidx_occ", 32'(o_occupancy), 2);

        // Re-insert the entry granted this cycle; entry 6 must never issue
        i_ready     = (NE'(1) << 4) | (NE'(1) << 8) | (NE'(1) << 6);
        i_ins_valid = 2'b01;
        i_ins_idx   = {4'd0, 4'd4};
        i_ins_fu    = {2'd0, 2'd1};
        expect_grant(0, 4);
        tick();
        i_ins_valid = '0;
        check("reins_err", 32'(o_ins_err), 0);
        check("reins_occ", 32'(o_occupancy), 2);
        i_fu_done = 3'b001;
        expect_grant(0, 8);
        expect_grant(1, 4);
        tick();
        i_fu_done = '0;
        check("reins_occ0", 32'(o_occupancy), 0);
        i_fu_done = 3'b011;
        tick();
        i_fu_done = '0;
        i_ready   = '0;
        check("reins_busy", 32'(o_fu_busy), 0);

        // Flush mid-operation
        ins(2'b01, 14, 2, 0, 0);
        i_ready = NE'(1) << 14;
        expect_grant(2, 14);
        tick();
        i_ready = '0;
        ins(2'b11, 0, 0, 1, 0);
        ins(2'b11, 2, 1, 3, 1);
        ins(2'b11, 4, 0, 5, 0);
        check("fl_occ6", 32'(o_occupancy), 6);
        check("fl_busy", 32'(o_fu_busy), 4);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("fl_occ0", 32'(o_occupancy), 0);
        check("fl_busy0", 32'(o_fu_busy), 0);
        check("fl_gv0", 32'(o_grant_valid), 0);
        ins(2'b01, 5, 2, 0, 0);
        i_ready = NE'(1) << 5;
        expect_grant(2, 5);
        tick();
        i_ready = '0;
        check("fl_post_busy", 32'(o_fu_busy), 4);
        check("fl_post_occ", 32'(o_occupancy), 0);

        tick();
        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
